data_memory: RTL and testbench

//  Responder end of the CPU data-memory port: services loads/stores issued by the
//  RV32IM core and holds the core with BUSYWAIT for a programmable access latency.

---
 rtl/data_memory_if.sv | 20 ++
 rtl/data_memory.sv | 144 ++++++++++++++
 tb/tb_data_memory.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/data_memory_if.sv
// CPU data-memory port bundle: load/store request lines from the core, load data and stall back.
// master = CPU side, slave = memory side.
interface data_memory_if;
  logic [3:0]  READ;
  logic [2:0]  WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITEDATA;
  logic [31:0] READDATA;
  logic        BUSYWAIT;

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA,
    input  READDATA, BUSYWAIT
  );

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA,
    output READDATA, BUSYWAIT
  );
endinterface

// File: rtl/data_memory.sv
// Byte-addressed data memory answering RV32 loads/stores; each access stalls the core for 1+LATENCY cycles
// via BUSYWAIT, then drops BUSYWAIT for one DONE cycle with READDATA valid.
module data_memory #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 5
) (
  input  logic          CLK,
  input  logic          RESET,
  data_memory_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                is_wr_q;
  logic [2:0]          f3_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic [7:0]          mem_q [2**ADDR_W];

  logic                req;
  logic                latch_en;
  logic                access_en;
  logic                busywait;
  logic [ADDR_W-1:0]   base;
  logic [31:0]         rd_word;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [31:0]         load_data;
  logic [3:0]          be;
  logic [31:0]         wlane;
  logic                unused_addr_hi;

  assign req            = bus.READ[3] | bus.WRITE[2];
  assign unused_addr_hi = ^bus.ADDRESS[31:ADDR_W];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_en  = 1'b0;
    access_en = 1'b0;
    busywait  = 1'b0;
    case (state_q)
      IDLE: begin
        busywait = req;
        if (req) begin
          latch_en = 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        busywait = 1'b1;
        if (cnt_q == 4'd0) begin
          access_en = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // Back to IDLE regardless of inputs so a request still held in DONE is not replayed.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (RESET) busywait = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      is_wr_q <= 1'b0;
      f3_q    <= 3'd0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        is_wr_q <= bus.WRITE[2];
        f3_q    <= bus.READ[2:0];
        size_q  <= bus.WRITE[1:0];
        addr_q  <= bus.ADDRESS[ADDR_W-1:0];
        wdata_q <= bus.WRITEDATA;
      end
      if (access_en && !is_wr_q) rdata_q <= load_data;
    end
  end

  // Alignment is handled by always fetching the whole word and selecting lanes from addr_q[1:0].
  always_comb begin
    base     = {addr_q[ADDR_W-1:2], 2'b00};
    rd_word  = {mem_q[base | ADDR_W'(3)], mem_q[base | ADDR_W'(2)],
                mem_q[base | ADDR_W'(1)], mem_q[base]};
    byte_sel = rd_word[{addr_q[1:0], 3'b000} +: 8];
    half_sel = rd_word[{addr_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    be    = 4'b1111;
    wlane = wdata_q;
    case (size_q)
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata_q;
      end
    endcase
  end

  // Storage is deliberately left out of reset; a reset during BUSY drops the pending write.
  always_ff @(posedge CLK) begin
    if (!RESET && access_en && is_wr_q) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem_q[base | ADDR_W'(k)] <= wlane[8*k +: 8];
      end
    end
  end

  assign bus.READDATA = rdata_q;
  assign bus.BUSYWAIT = busywait;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: vector table through a scoreboard queue, plus reset-mid-access and LATENCY=1 sequences.
module tb_data_memory;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  always #5 CLK = ~CLK;

  data_memory_if bus ();
  data_memory_if bus1 ();

  data_memory #(.ADDR_W(10), .LATENCY(5)) dut  (.CLK(CLK), .RESET(RESET), .bus(bus));
  data_memory #(.ADDR_W(10), .LATENCY(1)) dut1 (.CLK(CLK), .RESET(RESET), .bus(bus1));

  typedef struct {
    logic [3:0]  rd;
    logic [2:0]  wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_stall;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] exp_rd;
    int          exp_stall;
  } sb_t;

  sb_t  sbq[$];
  vec_t vt[18];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.READ      = 4'd0;
    bus.WRITE     = 3'd0;
    bus.ADDRESS   = 32'd0;
    bus.WRITEDATA = 32'd0;
  endtask

  // Holds the request until BUSYWAIT falls (DONE), counting stall cycles; drops it within DONE.
  task automatic access(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a,
                        input logic [31:0] wd, output int stall, output logic [31:0] rdata);
    @(negedge CLK);
    bus.READ      = rd;
    bus.WRITE     = wr;
    bus.ADDRESS   = a;
    bus.WRITEDATA = wd;
    stall = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.BUSYWAIT) begin
        stall++;
        @(negedge CLK);
      end else begin
        break;
      end
    end
    rdata = bus.READDATA;
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          stall;
    logic [31:0] rdata;
    sb_t         e;
    logic [5:0]  pat;

    vt[0]  = '{4'b0000, 3'b110, 32'h10,  32'hDEADBEEF, 32'h00000000, 6};
    vt[1]  = '{4'b1010, 3'b000, 32'h10,  32'h0,        32'hDEADBEEF, 6};
    vt[2]  = '{4'b0000, 3'b100, 32'h13,  32'h0000007F, 32'hDEADBEEF, 6};
    vt[3]  = '{4'b1010, 3'b000, 32'h10,  32'h0,        32'h7FADBEEF, 6};
    vt[4]  = '{4'b1000, 3'b000, 32'h11,  32'h0,        32'hFFFFFFBE, 6};
    vt[5]  = '{4'b1100, 3'b000, 32'h11,  32'h0,        32'h000000BE, 6};
    vt[6]  = '{4'b0000, 3'b101, 32'h22,  32'h00008001, 32'h000000BE, 6};
    vt[7]  = '{4'b1001, 3'b000, 32'h22,  32'h0,        32'hFFFF8001, 6};
    vt[8]  = '{4'b1101, 3'b000, 32'h23,  32'h0,        32'h00008001, 6};
    vt[9]  = '{4'b1010, 3'b110, 32'h30,  32'h12345678, 32'h00008001, 6};
    vt[10] = '{4'b1010, 3'b000, 32'h30,  32'h0,        32'h12345678, 6};
    vt[11] = '{4'b1011, 3'b000, 32'h412, 32'h0,        32'h7FADBEEF, 6};
    vt[12] = '{4'b1001, 3'b000, 32'h10,  32'h0,        32'hFFFFBEEF, 6};
    vt[13] = '{4'b0000, 3'b100, 32'h21,  32'h00000180, 32'hFFFFBEEF, 6};
    vt[14] = '{4'b1100, 3'b000, 32'h21,  32'h0,        32'h00000080, 6};
    vt[15] = '{4'b0000, 3'b110, 32'h40,  32'h11112222, 32'h00000080, 6};
    vt[16] = '{4'b1010, 3'b000, 32'h40,  32'h0,        32'h11112222, 6};
    vt[17] = '{4'b0000, 3'b000, 32'h40,  32'h0,        32'h11112222, 0};

    drive_idle();
    bus1.READ      = 4'd0;
    bus1.WRITE     = 3'd0;
    bus1.ADDRESS   = 32'd0;
    bus1.WRITEDATA = 32'd0;

    // Reset with a request present: BUSYWAIT must stay low, READDATA zero.
    bus.READ    = 4'b1010;
    bus.ADDRESS = 32'h10;
    repeat (2) @(negedge CLK);
    #1;
    check32("reset_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
    check32("reset_readdata", bus.READDATA, 32'd0);
    drive_idle();
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 18; i++) begin
      sbq.push_back('{i, vt[i].exp_rd, vt[i].exp_stall});
      access(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd, stall, rdata);
      e = sbq.pop_front();
      check32($sformatf("vec%0d_readdata", e.idx), rdata, e.exp_rd);
      check_int($sformatf("vec%0d_stall", e.idx), stall, e.exp_stall);
    end

    // Reset in the 3rd BUSY cycle of SW 0xCAFEF00D @0x40: the write must be dropped.
    @(negedge CLK);
    bus.WRITE     = 3'b110;
    bus.ADDRESS   = 32'h40;
    bus.WRITEDATA = 32'hCAFEF00D;
    #1;
    check32("midrst_idle_busywait", {31'd0, bus.BUSYWAIT}, 32'd1);
    repeat (3) @(negedge CLK);
    #1;
    check32("midrst_busy3_busywait", {31'd0, bus.BUSYWAIT}, 32'd1);
    RESET = 1'b1;
    drive_idle();
    #1;
    check32("midrst_forced_low", {31'd0, bus.BUSYWAIT}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check32("midrst_after_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
    check32("midrst_after_readdata", bus.READDATA, 32'd0);
    sbq.push_back('{100, 32'h11112222, 6});
    access(4'b1010, 3'b000, 32'h40, 32'h0, stall, rdata);
    e = sbq.pop_front();
    check32("midrst_lw_readdata", rdata, e.exp_rd);
    check_int("midrst_lw_stall", stall, e.exp_stall);

    // LATENCY=1 instance: store, then two back-to-back loads with the request held.
    @(negedge CLK);
    bus1.WRITE     = 3'b110;
    bus1.ADDRESS   = 32'h8;
    bus1.WRITEDATA = 32'hA1B2C3D4;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!bus1.BUSYWAIT) break;
      @(negedge CLK);
    end
    bus1.WRITE = 3'd0;
    @(negedge CLK);
    bus1.READ    = 4'b1010;
    bus1.ADDRESS = 32'h8;
    pat = 6'b110110;
    for (int k = 0; k < 6; k++) begin
      #1;
      check32($sformatf("lat1_busywait_c%0d", k), {31'd0, bus1.BUSYWAIT}, {31'd0, pat[5-k]});
      if (k == 2 || k == 5) check32($sformatf("lat1_readdata_c%0d", k), bus1.READDATA, 32'hA1B2C3D4);
      @(negedge CLK);
    end
    bus1.READ = 4'd0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
